// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and op decode helpers for muldiv_unit
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// rtl/muldiv_divstep.sv - one combinational restoring-division step
module muldiv_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, bit_in};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // After a successful subtract the remainder is below the divisor, so it fits WIDTH bits.
    assign rem_out = WIDTH'(q_bit ? (shifted - {1'b0, divisor}) : shifted);

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning HI/LO; MULDIV_FAST_MULT_EN selects a one-cycle multiplier
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] opnd;
    logic             neg_q, neg_r, is_div;

    logic             issue, last_iter, sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign issue     = start && !cancel;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign sgn       = is_signed_op(op);
    assign a_neg     = sgn && a[WIDTH-1];
    assign b_neg     = sgn && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [WIDTH-1:0] rem_step;
    logic             q_step;
    logic [W2-1:0]    div_next;

    muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in  (acc[W2-1:WIDTH]),
        .divisor (opnd),
        .bit_in  (acc[WIDTH-1]),
        .rem_out (rem_step),
        .q_bit   (q_step)
    );
    assign div_next = {rem_step, acc[WIDTH-2:0], q_step};

    logic [W2-1:0]    prod_mag, prod;
    logic [WIDTH-1:0] quo, rem, lo_div, hi_div;

`ifdef MULDIV_FAST_MULT_EN
    assign prod_mag = W2'(acc[WIDTH-1:0]) * W2'(opnd);
`else
    assign prod_mag = acc;
`endif
    assign prod   = neg_q ? -prod_mag : prod_mag;
    assign quo    = acc[WIDTH-1:0];
    assign rem    = acc[W2-1:WIDTH];
    // A zero divisor leaves remainder = |a|; with the sign fix-up that restores a itself.
    assign lo_div = (opnd == '0) ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
    assign hi_div = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue && is_mult_op(op)) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_nxt = FIX;
`else
                    state_nxt = MUL;
`endif
                end else if (issue && is_div_op(op)) begin
                    state_nxt = DIV;
                end
            end
            MUL:     state_nxt = cancel ? IDLE : (last_iter ? FIX : MUL);
            DIV:     state_nxt = cancel ? IDLE : (last_iter ? FIX : DIV);
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt   <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        if (is_mult_op(op)) begin
                            acc    <= {{WIDTH{1'b0}}, b_mag};
                            opnd   <= a_mag;
                            is_div <= 1'b0;
                        end else if (is_div_op(op)) begin
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            opnd   <= b_mag;
                            is_div <= 1'b1;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (!cancel) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= hi_div;
                            lo <= lo_div;
                        end else begin
                            hi <= prod[W2-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = '0, b = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: return sx * sy;
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    int          rem_cyc;
    logic [31:0] e_hi, e_lo, p_hi, p_lo;
    logic        e_done;
    logic [63:0] res;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_cyc = 0; e_hi = '0; e_lo = '0; e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (rem_cyc > 0) begin
                if (cancel) rem_cyc = 0;
                else begin
                    rem_cyc--;
                    if (rem_cyc == 0) begin
                        e_hi = p_hi; e_lo = p_lo; e_done = 1'b1;
                    end
                end
            end else if (start && !cancel) begin
                if (op <= 3'd3) begin
                    res = ref_result(op, a, b);
                    p_hi = res[63:32];
                    p_lo = res[31:0];
                    rem_cyc = (op <= 3'd1) ? MUL_LAT : DIV_LAT;
                end else if (op == 3'd4) e_hi = a;
                else if (op == 3'd5) e_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'b0, busy}, {31'b0, rem_cyc > 0});
        check("done", {31'b0, done}, {31'b0, e_done});
        check("hi", hi, e_hi);
        check("lo", lo, e_lo);
        check("busy_done_excl", {31'b0, busy & done}, 32'd0);
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b111;
        t0 = cyc;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        else check({name, "_latency"}, cyc - t0, exp_lat);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(o, x, y);
        wait_done(name, (o <= 3'd1) ? MUL_LAT : DIV_LAT);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        #2;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_neg", 3'd2, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_op("div_zero", 3'd2, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
        run_op("divu_zero_neg", 3'd2, 32'hFFFFFF00, 32'h0, 32'hFFFFFF00, 32'hFFFFFFFF);
        run_op("mult_minmin", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);

        @(negedge clk);
        issue(3'd4, 32'hDEADBEEF, 32'h0);
        check("mthi_next", hi, 32'hDEADBEEF);
        issue(3'd5, 32'h0000CAFE, 32'h0);
        check("mtlo_next", lo, 32'h0000CAFE);
        check("mt_busy", {31'b0, busy}, 32'd0);

        issue(3'd3, 32'd50, 32'd3);
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk); #1 cancel = 1'b0;
        check("cancel_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("cancel_hi", hi, 32'hDEADBEEF);
        check("cancel_lo", lo, 32'h0000CAFE);

        cancel = 1'b1;
        issue(3'd4, 32'h11111111, 32'h0);
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_idle_mthi", hi, 32'hDEADBEEF);

        issue(3'd3, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1 start = 1'b0; op = 3'b111;
        t0 = t0 + 0;
        begin
            int n = 0;
            while (!done && n < 100) begin @(negedge clk); n++; end
            check("busy_start_done", {31'b0, done}, 32'd1);
        end
        check("busy_start_hi", hi, 32'd2);
        check("busy_start_lo", lo, 32'd14);
        repeat (5) @(negedge clk);
        check("busy_start_stable", lo, 32'd14);

        issue(3'd1, 32'd5, 32'd6);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        run_op("multu_after_rst", 3'd1, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair of the five-stage pipeline. It supersedes the single-cycle HI/LO file. It executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO immediately, and raises busy so the decode stage can stall MFHI/MFLO and further mult/div issue. It sits beside the EX stage; decode reads hi/lo directly.

## Interface
- WIDTH, 32, operand and HI/LO width; legal range 4..64.
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  issue request, sampled each rising edge.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP.
- a  input  WIDTH  rs operand (dividend / multiplicand / MT source).
- b  input  WIDTH  rt operand (divisor / multiplier).
- cancel  input  1  flush from exception/ERET; aborts the operation in flight.
- busy  output  1  operation in flight; decode must stall MFHI/MFLO and any start.
- done  output  1  one-cycle pulse after HI/LO are written by a mult/div.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

## Operation
- States: IDLE, MUL, DIV, FIX. Reset: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- IDLE plus start with MULT/MULTU: latch |a|, |b| (signed ops) or raw (unsigned), and latch result sign = a[W-1]^b[W-1] (signed only). Go to MUL.
- IDLE plus start with DIV/DIVU: latch magnitudes, quotient sign a^b and remainder sign a[W-1] (signed only). Go to DIV.
- MTHI/MTLO in IDLE: write hi (or lo) = a on the sampling edge; no busy, no done. NOP: no effect.
- MUL: shift-add one multiplier bit per cycle for WIDTH cycles into a 2*WIDTH accumulator, then FIX.
- DIV: restoring division, one quotient bit per cycle for WIDTH cycles, then FIX.
- FIX: apply two's-complement sign correction; write {hi,lo} = product (hi = upper WIDTH bits) or lo = quotient, hi = remainder; go to IDLE; done=1 in the following cycle.
- Divide by zero (b=0, any sign): normal latency, lo = all ones, hi = a unmodified.
- DIV of most-negative by -1: lo = most-negative, hi = 0 (wraps, no trap).
- start while busy: ignored; no state change.
- cancel in MUL/DIV/FIX: next state IDLE; hi/lo unchanged; no done. cancel in IDLE blocks a same-cycle start (cancel wins), including MTHI/MTLO.
- Asynchronous reset mid-operation: immediately returns to the reset values.

## Timing
- Start edge E0. Iterative mult/div: iterations on E1..E(WIDTH), FIX writes on E(WIDTH+1). busy is high from after E0 until E(WIDTH+1); done is high for the one cycle after E(WIDTH+1).
- busy and done are never high together. A new start is legal in the same cycle done is high.
- MTHI/MTLO: hi/lo are visible the cycle after E0.
- hi/lo change only on FIX, on MTHI/MTLO, or on reset.

## Configuration
- MULDIV_FAST_MULT_EN defined: MULT/MULTU skip MUL. The E0 edge latches the operands and goes straight to FIX, and FIX uses a single-cycle WIDTH×WIDTH multiplier. hi/lo are written on E1, busy is high for exactly one cycle, and done is high after E1. Divide is unaffected.
- Macro undefined: iterative shift-add multiply as described in Operation. No multiplier is inferred.

## Structure
- Shared package muldiv_pkg holds the op encodings (OP_MULT..OP_MTLO) and the state enum (IDLE, MUL, DIV, FIX).
- Sub-module muldiv_divstep: a combinational single restoring step (partial remainder, divisor, next dividend bit in; new remainder and quotient bit out), instantiated once.

## Test plan
WIDTH=32 throughout.
- MULT a=FFFFFFFD (-3), b=5: hi=FFFFFFFF, lo=FFFFFFF1. done 33 cycles after start (1 cycle with MULDIV_FAST_MULT_EN); busy high throughout.
- DIVU a=100, b=7: lo=14, hi=2. DIV a=-7, b=2: lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF: lo=80000000, hi=0.
- DIV a=1234, b=0: lo=FFFFFFFF, hi=1234 after normal latency.
- MTHI a=DEADBEEF, then MTLO a=0000CAFE on consecutive cycles: hi/lo updated next cycle; busy and done stay 0.
- DIVU started, then cancel at iteration 10: IDLE next cycle, hi/lo keep their old values, no done. Also a second start while busy is ignored and the result equals the first op's.
- Reset asserted mid-MULTU: hi=lo=0 and busy=0 immediately. After release, a fresh MULTU FFFFFFFF×2 gives hi=1, lo=FFFFFFFE.
